// File: rtl/dda_ray_stepper.sv
// dda_ray_stepper
//   DDA grid-traversal engine for one raycaster ray over an 8x8 tile map.
//   Each RUN cycle it presents {cur_y, cur_x} to the map ROM and samples the
//   zero-latency tile. On a non-empty tile it latches hit cell, side, wall
//   type and perpendicular distance. On an empty tile it steps one cell
//   along the axis with the smaller side distance; ties step on x.
//
// Optional feature macro: DDA_STEP_LIMIT_EN
//   When defined, the ray is aborted with timeout_o = 1 if it is on an empty
//   cell after MAX_STEPS steps. When undefined there is no step counter and
//   timeout_o is tied low.
//
// Ports
//   clk_i                      system clock
//   rst_i                      synchronous active-high reset
//   start_i                    launch a ray; sampled only in IDLE
//   cell_x_i, cell_y_i   [2:0] starting cell
//   step_x_neg_i/_y_neg_i      1: step -1 on that axis, 0: step +1
//   side_dist_x/y_init_i[15:0] initial side distances, unsigned Q8.8
//   delta_dist_x/y_i    [15:0] per-cell increments, unsigned Q8.8
//   map_addr_o           [5:0] {cur_y, cur_x} to the map ROM
//   map_data_i           [1:0] tile at map_addr_o, same cycle
//   busy_o                     high in RUN and DONE
//   done_o                     one-cycle pulse; results valid from this cycle
//   hit_x_o, hit_y_o     [2:0] cell where traversal ended
//   hit_side_o                 0: last step was x, 1: y
//   wall_type_o          [1:0] tile at hit cell; 0 on timeout
//   perp_dist_o         [15:0] perpendicular distance, unsigned Q8.8
//   timeout_o                  step limit reached without a hit

module dda_ray_stepper #(
    parameter int MAX_STEPS = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  cell_x_i,
    input  logic [2:0]  cell_y_i,
    input  logic        step_x_neg_i,
    input  logic        step_y_neg_i,
    input  logic [15:0] side_dist_x_init_i,
    input  logic [15:0] side_dist_y_init_i,
    input  logic [15:0] delta_dist_x_i,
    input  logic [15:0] delta_dist_y_i,
    output logic [5:0]  map_addr_o,
    input  logic [1:0]  map_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  hit_x_o,
    output logic [2:0]  hit_y_o,
    output logic        hit_side_o,
    output logic [1:0]  wall_type_o,
    output logic [15:0] perp_dist_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  cur_x_q, cur_y_q;
    logic [15:0] sdx_q, sdy_q;
    logic [15:0] dx_q, dy_q;
    logic        x_neg_q, y_neg_q;
    logic        side_q;
    logic        moved_q;     // at least one step taken since start
    logic        busy_q, done_q, hit_side_q;
    logic [2:0]  hit_x_q, hit_y_q;
    logic [1:0]  wall_q;
    logic [15:0] perp_q;

    logic        step_x;
    logic [16:0] sdx_sum, sdy_sum;
    logic [15:0] sdx_d, sdy_d;
    logic [2:0]  cur_x_d, cur_y_d;
    logic [15:0] perp_d;

`ifdef DDA_STEP_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_STEPS + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
`endif

    always_comb begin
        step_x  = (sdx_q <= sdy_q);
        sdx_sum = {1'b0, sdx_q} + {1'b0, dx_q};
        sdy_sum = {1'b0, sdy_q} + {1'b0, dy_q};
        // Saturate instead of wrapping so far walls never look near.
        sdx_d   = sdx_sum[16] ? 16'hFFFF : sdx_sum[15:0];
        sdy_d   = sdy_sum[16] ? 16'hFFFF : sdy_sum[15:0];
        cur_x_d = x_neg_q ? (cur_x_q - 3'd1) : (cur_x_q + 3'd1);
        cur_y_d = y_neg_q ? (cur_y_q - 3'd1) : (cur_y_q + 3'd1);
        // Side distance already includes one delta past the hit boundary.
        if (!moved_q)
            perp_d = 16'h0000;
        else if (side_q)
            perp_d = sdy_q - dy_q;
        else
            perp_d = sdx_q - dx_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cur_x_q    <= 3'd0;
            cur_y_q    <= 3'd0;
            sdx_q      <= 16'h0000;
            sdy_q      <= 16'h0000;
            dx_q       <= 16'h0000;
            dy_q       <= 16'h0000;
            x_neg_q    <= 1'b0;
            y_neg_q    <= 1'b0;
            side_q     <= 1'b0;
            moved_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_x_q    <= 3'd0;
            hit_y_q    <= 3'd0;
            hit_side_q <= 1'b0;
            wall_q     <= 2'd0;
            perp_q     <= 16'h0000;
`ifdef DDA_STEP_LIMIT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cur_x_q <= cell_x_i;
                        cur_y_q <= cell_y_i;
                        sdx_q   <= side_dist_x_init_i;
                        sdy_q   <= side_dist_y_init_i;
                        dx_q    <= delta_dist_x_i;
                        dy_q    <= delta_dist_y_i;
                        x_neg_q <= step_x_neg_i;
                        y_neg_q <= step_y_neg_i;
                        side_q  <= 1'b0;
                        moved_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
`ifdef DDA_STEP_LIMIT_EN
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (map_data_i != 2'd0) begin
                        hit_x_q    <= cur_x_q;
                        hit_y_q    <= cur_y_q;
                        hit_side_q <= side_q;
                        wall_q     <= map_data_i;
                        perp_q     <= perp_d;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
`ifdef DDA_STEP_LIMIT_EN
                    else if (cnt_q == CNT_W'(MAX_STEPS)) begin
                        hit_x_q    <= cur_x_q;
                        hit_y_q    <= cur_y_q;
                        hit_side_q <= side_q;
                        wall_q     <= 2'd0;
                        perp_q     <= 16'hFFFF;
                        timeout_q  <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
`endif
                    else begin
                        moved_q <= 1'b1;
                        if (step_x) begin
                            sdx_q   <= sdx_d;
                            cur_x_q <= cur_x_d;
                            side_q  <= 1'b0;
                        end else begin
                            sdy_q   <= sdy_d;
                            cur_y_q <= cur_y_d;
                            side_q  <= 1'b1;
                        end
`ifdef DDA_STEP_LIMIT_EN
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign map_addr_o  = {cur_y_q, cur_x_q};
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign hit_x_o     = hit_x_q;
    assign hit_y_o     = hit_y_q;
    assign hit_side_o  = hit_side_q;
    assign wall_type_o = wall_q;
    assign perp_dist_o = perp_q;
`ifdef DDA_STEP_LIMIT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule
